// File: rtl/maze_pkg.sv
// Shared types and helpers for the maze player controller.
// Used by maze_player_ctrl and btn_conditioner.
package maze_pkg;

  localparam int MAZE_DIM = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    PLAY,
    WON
  } player_state_t;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_LEFT,
    DIR_DOWN,
    DIR_RIGHT
  } dir_t;

  function automatic logic [7:0] cell_idx(
    input logic [3:0] x,
    input logic [3:0] y
  );
    return {4'b0, x} + {y, 4'b0};
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Button synchronizer, optional debouncer and registered rising-edge pulse.
// Debouncer is built only when MAZE_PLAYER_DEBOUNCE_EN is defined.
module btn_conditioner #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic pulse
);

  logic s0;
  logic s1;
  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= btn;
      s1 <= s0;
    end
  end

`ifdef MAZE_PLAYER_DEBOUNCE_EN
  logic [19:0] cnt;
  logic        deb;

  // level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (s1 != deb) begin
      if (cnt == DEBOUNCE_CYCLES - 20'd1) begin
        cnt <= '0;
        deb <= s1;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign level = deb;
`else
  assign level = s1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= level;
      pulse <= level & ~prev;
    end
  end

endmodule

// File: rtl/maze_player_ctrl.sv
// Moves a player token through a carved maze from four push-buttons.
// Optional debounce: define MAZE_PLAYER_DEBOUNCE_EN.
module maze_player_ctrl
  import maze_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter int          MOVE_CNT_W      = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [MAZE_DIM*MAZE_DIM-1:0]   maze_data,
  input  logic [4:0]                     maze_width,
  input  logic [4:0]                     maze_height,
  input  logic                           carve_finished,
  input  logic [3:0]                     finish_x,
  input  logic [3:0]                     finish_y,
  input  logic                           btn_up,
  input  logic                           btn_left,
  input  logic                           btn_down,
  input  logic                           btn_right,
  output logic [3:0]                     player_x,
  output logic [3:0]                     player_y,
  output logic [MOVE_CNT_W-1:0]          move_count,
  output logic                           playing,
  output logic                           won
);

  player_state_t state, state_n;

  logic [3:0] raw;
  logic [3:0] lvl;
  logic [3:0] pls;

  assign raw = {btn_right, btn_down, btn_left, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk  (clk),
      .reset(reset),
      .btn  (raw[i]),
      .level(lvl[i]),
      .pulse(pls[i])
    );
  end

  logic       at_finish;
  logic       hit;
  logic       in_bounds;
  logic       mv_ok;
  dir_t       dir;
  logic [3:0] tx;
  logic [3:0] ty;

  assign at_finish = (player_x == finish_x) && (player_y == finish_y);

  always_comb begin
    hit = 1'b1;
    dir = DIR_UP;
    priority case (1'b1)
      pls[DIR_UP]:    dir = DIR_UP;
      pls[DIR_LEFT]:  dir = DIR_LEFT;
      pls[DIR_DOWN]:  dir = DIR_DOWN;
      pls[DIR_RIGHT]: dir = DIR_RIGHT;
      default:        hit = 1'b0;
    endcase
  end

  // bounds are checked before indexing so the cell index never wraps
  always_comb begin
    tx        = player_x;
    ty        = player_y;
    in_bounds = 1'b0;
    unique case (dir)
      DIR_UP: begin
        in_bounds = player_y != 4'd0;
        ty        = player_y - 4'd1;
      end
      DIR_LEFT: begin
        in_bounds = player_x != 4'd0;
        tx        = player_x - 4'd1;
      end
      DIR_DOWN: begin
        in_bounds = ({1'b0, player_y} + 5'd1) < maze_height;
        ty        = player_y + 4'd1;
      end
      DIR_RIGHT: begin
        in_bounds = ({1'b0, player_x} + 5'd1) < maze_width;
        tx        = player_x + 4'd1;
      end
    endcase
    mv_ok = hit && in_bounds && maze_data[cell_idx(tx, ty)];
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (carve_finished) state_n = ARM;
      ARM:  if (lvl == 4'b0)    state_n = PLAY;
      PLAY: if (at_finish)      state_n = WON;
      WON:  state_n = WON;
    endcase
    if (!carve_finished) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      playing <= 1'b0;
      won     <= 1'b0;
    end else begin
      state   <= state_n;
      playing <= (state == PLAY) && carve_finished;
      won     <= (state == WON) && carve_finished;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      player_x   <= '0;
      player_y   <= '0;
      move_count <= '0;
    end else if (!carve_finished || state == IDLE) begin
      player_x   <= '0;
      player_y   <= '0;
      move_count <= '0;
    end else if (state == PLAY && !at_finish && mv_ok) begin
      player_x <= tx;
      player_y <= ty;
      if (move_count != '1) move_count <= move_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Self-checking bench for maze_player_ctrl.
// Define MAZE_PLAYER_DEBOUNCE_EN to also exercise the debouncer.
module tb_maze_player_ctrl;

`ifdef MAZE_PLAYER_DEBOUNCE_EN
  localparam logic [19:0] DEB    = 20'd8;
  localparam int          HOLD   = 12;
  localparam int          SETTLE = 24;
`else
  localparam logic [19:0] DEB    = 20'd500000;
  localparam int          HOLD   = 2;
  localparam int          SETTLE = 6;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] maze_data;
  logic [4:0]   maze_width;
  logic [4:0]   maze_height;
  logic         carve_finished;
  logic [3:0]   finish_x;
  logic [3:0]   finish_y;
  logic         btn_up;
  logic         btn_left;
  logic         btn_down;
  logic         btn_right;
  logic [3:0]   player_x;
  logic [3:0]   player_y;
  logic [9:0]   move_count;
  logic         playing;
  logic         won;

  maze_player_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .MOVE_CNT_W     (10)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .maze_data     (maze_data),
    .maze_width    (maze_width),
    .maze_height   (maze_height),
    .carve_finished(carve_finished),
    .finish_x      (finish_x),
    .finish_y      (finish_y),
    .btn_up        (btn_up),
    .btn_left      (btn_left),
    .btn_down      (btn_down),
    .btn_right     (btn_right),
    .player_x      (player_x),
    .player_y      (player_y),
    .move_count    (move_count),
    .playing       (playing),
    .won           (won)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         m;
    logic [3:0] btn;
    int         ex;
    int         ey;
    int         ec;
  } vec_t;

  localparam int NV = 16;

  int           checks;
  int           failures;
  vec_t         vt[NV];
  vec_t         exp_q[$];
  logic [255:0] md[4];
  int           mw[4];
  int           mh[4];
  int           mfx[4];
  int           mfy[4];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_right, btn_down, btn_left, btn_up} = b;
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clk);
    set_btn(b);
    repeat (HOLD) @(negedge clk);
    set_btn(4'b0);
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic wait_playing(input string n);
    int i;
    i = 0;
    while (!playing && i < 60) begin
      @(negedge clk);
      i++;
    end
    chk(n, int'(playing), 1);
  endtask

  task automatic start(input int m);
    @(negedge clk);
    carve_finished = 1'b0;
    repeat (2) @(negedge clk);
    maze_data      = md[m];
    maze_width     = 5'(mw[m]);
    maze_height    = 5'(mh[m]);
    finish_x       = 4'(mfx[m]);
    finish_y       = 4'(mfy[m]);
    carve_finished = 1'b1;
    wait_playing($sformatf("start%0d_playing", m));
    chk($sformatf("start%0d_pos", m), int'({player_y, player_x}), 0);
    chk($sformatf("start%0d_cnt", m), int'(move_count), 0);
  endtask

  initial begin
    int cur;
    int i;
    vec_t e;
    checks   = 0;
    failures = 0;

    // maze 0: (0,0),(0,1) carved, (1,0) wall
    md[0] = '0; md[0][0] = 1'b1; md[0][16] = 1'b1;
    mw[0] = 4; mh[0] = 4; mfx[0] = 3; mfy[0] = 3;
    // maze 1: row 0 carved plus cell 4 outside a 4-wide maze
    md[1] = '0; for (int k = 0; k < 5; k++) md[1][k] = 1'b1;
    mw[1] = 4; mh[1] = 4; mfx[1] = 0; mfy[1] = 3;
    // maze 2: path to (1,1) with (1,0) and (2,1) both carved
    md[2] = '0; md[2][0] = 1'b1; md[2][1] = 1'b1;
    md[2][17] = 1'b1; md[2][18] = 1'b1;
    mw[2] = 4; mh[2] = 4; mfx[2] = 3; mfy[2] = 3;
    // maze 3: (0,0)->(1,0)->(2,0), finish at (2,0)
    md[3] = '0; md[3][0] = 1'b1; md[3][1] = 1'b1; md[3][2] = 1'b1;
    mw[3] = 4; mh[3] = 4; mfx[3] = 2; mfy[3] = 0;

    // btn = {right, down, left, up}
    vt[0]  = '{0, 4'b1000, 0, 0, 0};
    vt[1]  = '{0, 4'b0001, 0, 0, 0};
    vt[2]  = '{0, 4'b0010, 0, 0, 0};
    vt[3]  = '{0, 4'b0100, 0, 1, 1};
    vt[4]  = '{0, 4'b0001, 0, 0, 2};
    vt[5]  = '{0, 4'b0100, 0, 1, 3};
    vt[6]  = '{0, 4'b0100, 0, 1, 3};
    vt[7]  = '{1, 4'b1000, 1, 0, 1};
    vt[8]  = '{1, 4'b1000, 2, 0, 2};
    vt[9]  = '{1, 4'b1000, 3, 0, 3};
    vt[10] = '{1, 4'b1000, 3, 0, 3};
    vt[11] = '{1, 4'b0100, 3, 0, 3};
    vt[12] = '{2, 4'b1000, 1, 0, 1};
    vt[13] = '{2, 4'b0100, 1, 1, 2};
    vt[14] = '{2, 4'b1001, 1, 0, 3};
    vt[15] = '{3, 4'b1000, 1, 0, 1};

    reset          = 1'b1;
    carve_finished = 1'b0;
    maze_data      = '0;
    maze_width     = 5'd16;
    maze_height    = 5'd16;
    finish_x       = 4'd0;
    finish_y       = 4'd0;
    set_btn(4'b0);
    repeat (3) @(negedge clk);
    chk("rst_pos", int'({player_y, player_x}), 0);
    chk("rst_cnt", int'(move_count), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_won", int'(won), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_carve", int'(playing), 0);

    cur = -1;
    for (int v = 0; v < NV; v++) begin
      if (vt[v].m != cur) begin
        cur = vt[v].m;
        start(cur);
      end
      exp_q.push_back(vt[v]);
      press(vt[v].btn);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_x", v), int'(player_x), e.ex);
      chk($sformatf("vec%0d_y", v), int'(player_y), e.ey);
      chk($sformatf("vec%0d_cnt", v), int'(move_count), e.ec);
    end

    // second move onto the finish tile; won follows two cycles later
    @(negedge clk);
    btn_right = 1'b1;
    i = 0;
    while (player_x != 4'd2 && i < 60) begin
      @(negedge clk);
      if (i == HOLD - 1) btn_right = 1'b0;
      i++;
    end
    btn_right = 1'b0;
    chk("win_reach_x", int'(player_x), 2);
    chk("win_cnt", int'(move_count), 2);
    chk("win_t0", int'(won), 0);
    @(negedge clk);
    chk("win_t1", int'(won), 0);
    @(negedge clk);
    chk("win_t2", int'(won), 1);
    chk("win_playing", int'(playing), 0);
    press(4'b0010);
    chk("won_hold_x", int'(player_x), 2);
    chk("won_hold_cnt", int'(move_count), 2);
    chk("won_stays", int'(won), 1);

    // carve_finished falling mid-game
    start(2);
    press(4'b1000);
    chk("cf_pre_x", int'(player_x), 1);
    @(negedge clk);
    carve_finished = 1'b0;
    @(negedge clk);
    chk("cf_playing", int'(playing), 0);
    chk("cf_pos", int'({player_y, player_x}), 0);
    chk("cf_cnt", int'(move_count), 0);

    // asynchronous reset mid-play
    start(2);
    press(4'b1000);
    press(4'b0100);
    chk("rp_pre_pos", int'({player_y, player_x}), 8'h11);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rp_pos", int'({player_y, player_x}), 0);
    chk("rp_cnt", int'(move_count), 0);
    chk("rp_playing", int'(playing), 0);
    carve_finished = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rp_idle", int'(playing), 0);
    carve_finished = 1'b1;
    wait_playing("rp_rearm");

`ifdef MAZE_PLAYER_DEBOUNCE_EN
    start(0);
    @(negedge clk);
    btn_down = 1'b1;
    repeat (5) @(negedge clk);
    btn_down = 1'b0;
    repeat (30) @(negedge clk);
    chk("deb_glitch_pos", int'({player_y, player_x}), 0);
    chk("deb_glitch_cnt", int'(move_count), 0);
    press(4'b0100);
    chk("deb_press_pos", int'({player_y, player_x}), 8'h10);
    chk("deb_press_cnt", int'(move_count), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
